// File: rtl/spi_target.sv
// -----------------------------------------------------------------------------
// spi_target -- SPI mode-0 target (peripheral) running entirely in the MHZ48
// clock domain. The host-side pins are synchronized and edge-detected; a
// single-byte TX buffer feeds the outgoing shift register at each byte slot,
// and each completed incoming byte is presented on RXD with a RXVALID strobe.
//
// Ports
//   MHZ48    in   master clock, all state on rising edge
//   nRES     in   asynchronous active-low reset
//   nCS      in   host chip select (active-low, asynchronous)
//   SCLK     in   host SPI clock, mode 0 (asynchronous)
//   MOSI     in   host->target data, MSB first
//   MISO     out  target->host data, MSB first (1 while not selected)
//   MISO_OE  out  drive-enable for MISO (equals ACTIVE)
//   TXD      in   next byte to transmit
//   TXLOAD   in   1-cycle strobe capturing TXD into the TX buffer
//   TXRDY    out  TX buffer empty, TXLOAD will be accepted
//   TXUND    out  sticky: a byte slot started with an empty TX buffer
//   RXD      out  last complete received byte
//   RXVALID  out  1-cycle strobe, RXD updated
//   ACTIVE   out  synchronized chip select is asserted
// -----------------------------------------------------------------------------
module spi_target (
    input  logic       MHZ48,
    input  logic       nRES,
    input  logic       nCS,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    output logic       MISO_OE,
    input  logic [7:0] TXD,
    input  logic       TXLOAD,
    output logic       TXRDY,
    output logic       TXUND,
    output logic [7:0] RXD,
    output logic       RXVALID,
    output logic       ACTIVE
);

    // Synchronizer chains: bit 0 = first flop, bit 1 = synchronized value,
    // bit 2 = previous synchronized value used for edge detection.
    logic [2:0] ncs_q;
    logic [2:0] sclk_q;
    logic [2:0] mosi_q;

    logic       active_q;
    logic [2:0] cnt_q;
    logic       byte_done_q;   // at least one full byte seen in this selection
    logic [7:0] rx_q;
    logic [7:0] sh_q;
    logic [7:0] txbuf_q;
    logic       txrdy_q;
    logic       txund_q;
    logic [7:0] rxd_q;
    logic       rxvalid_q;

    logic       ncs_fall;
    logic       ncs_rise;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       consume;
    logic       accept;
    logic [7:0] load_val;
    logic [7:0] rx_d;

    assign ncs_fall  = ~ncs_q[1] &  ncs_q[2];
    assign ncs_rise  =  ncs_q[1] & ~ncs_q[2];
    assign sclk_rise =  sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] &  sclk_q[2];

    // A byte slot starts at selection and on the SCLK fall that closes a byte.
    assign consume = ncs_fall |
                     (active_q & ~ncs_rise & sclk_fall & (cnt_q == 3'd0) & byte_done_q);

    // A load coinciding with a slot start is taken even if the buffer was
    // full: the old contents leave for the shift register in the same cycle.
    assign accept   = TXLOAD & (txrdy_q | consume);
    assign load_val = txrdy_q ? 8'hFF : txbuf_q;

    // MOSI is taken from the third stage; it is one cycle older than the
    // detected SCLK edge, still deep inside the host's setup window.
    assign rx_d = {rx_q[6:0], mosi_q[2]};

    always_ff @(posedge MHZ48 or negedge nRES) begin
        if (!nRES) begin
            ncs_q       <= 3'b111;
            sclk_q      <= 3'b000;
            mosi_q      <= 3'b111;
            active_q    <= 1'b0;
            cnt_q       <= 3'd0;
            byte_done_q <= 1'b0;
            rx_q        <= 8'h00;
            sh_q        <= 8'h00;
            txbuf_q     <= 8'h00;
            txrdy_q     <= 1'b1;
            txund_q     <= 1'b0;
            rxd_q       <= 8'h00;
            rxvalid_q   <= 1'b0;
        end else begin
            ncs_q     <= {ncs_q[1:0], nCS};
            sclk_q    <= {sclk_q[1:0], SCLK};
            mosi_q    <= {mosi_q[1:0], MOSI};
            active_q  <= ~ncs_q[1];
            rxvalid_q <= 1'b0;

            if (ncs_rise) begin
                // Deselect: drop any partial byte, keep TX buffer and RXD.
                cnt_q       <= 3'd0;
                rx_q        <= 8'h00;
                sh_q        <= 8'h00;
                byte_done_q <= 1'b0;
            end else if (ncs_fall) begin
                cnt_q       <= 3'd0;
                rx_q        <= 8'h00;
                sh_q        <= load_val;
                byte_done_q <= 1'b0;
            end else if (active_q && sclk_rise) begin
                rx_q  <= rx_d;
                cnt_q <= cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    rxd_q       <= rx_d;
                    rxvalid_q   <= 1'b1;
                    byte_done_q <= 1'b1;
                end
            end else if (active_q && sclk_fall) begin
                if (cnt_q != 3'd0) begin
                    sh_q <= {sh_q[6:0], 1'b0};
                end else if (byte_done_q) begin
                    sh_q <= load_val;
                end
            end

            if (accept) begin
                txbuf_q <= TXD;
                txrdy_q <= 1'b0;
            end else if (consume) begin
                txrdy_q <= 1'b1;
            end

            // Underrun set wins over the clear from a simultaneous load.
            if (consume && txrdy_q) begin
                txund_q <= 1'b1;
            end else if (accept) begin
                txund_q <= 1'b0;
            end
        end
    end

    assign ACTIVE  = active_q;
    assign MISO_OE = active_q;
    assign MISO    = active_q ? sh_q[7] : 1'b1;
    assign TXRDY   = txrdy_q;
    assign TXUND   = txund_q;
    assign RXD     = rxd_q;
    assign RXVALID = rxvalid_q;

endmodule

// File: tb/tb_spi_target.sv
module tb_spi_target;

    logic       MHZ48 = 1'b0;
    logic       nRES;
    logic       nCS;
    logic       SCLK;
    logic       MOSI;
    logic       MISO;
    logic       MISO_OE;
    logic [7:0] TXD;
    logic       TXLOAD;
    logic       TXRDY;
    logic       TXUND;
    logic [7:0] RXD;
    logic       RXVALID;
    logic       ACTIVE;

    int errors  = 0;
    int checks  = 0;
    int rxv_cnt = 0;

    // Reference model: one-byte TX buffer, sticky underrun, last received byte.
    logic [7:0] m_buf;
    logic       m_full;
    logic       m_und;
    logic [7:0] m_rxd;
    logic [7:0] cur_tx;   // byte the target should be sending in this slot

    spi_target dut (
        .MHZ48   (MHZ48),
        .nRES    (nRES),
        .nCS     (nCS),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .MISO_OE (MISO_OE),
        .TXD     (TXD),
        .TXLOAD  (TXLOAD),
        .TXRDY   (TXRDY),
        .TXUND   (TXUND),
        .RXD     (RXD),
        .RXVALID (RXVALID),
        .ACTIVE  (ACTIVE)
    );

    always #10 MHZ48 = ~MHZ48;

    always @(posedge MHZ48) begin
        if (RXVALID === 1'b1) rxv_cnt <= rxv_cnt + 1;
    end

    task automatic tick();
        @(posedge MHZ48);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_buf  = 8'h00;
        m_full = 1'b0;
        m_und  = 1'b0;
        m_rxd  = 8'h00;
    endtask

    task automatic model_load(input logic [7:0] v);
        if (!m_full) begin
            m_buf  = v;
            m_full = 1'b1;
            m_und  = 1'b0;
        end
    endtask

    // Start of a byte slot: take the buffered byte or send all-ones.
    task automatic model_slot(output logic [7:0] b);
        if (m_full) begin
            b      = m_buf;
            m_full = 1'b0;
        end else begin
            b     = 8'hFF;
            m_und = 1'b1;
        end
    endtask

    task automatic host_load(input logic [7:0] v);
        TXD    = v;
        TXLOAD = 1'b1;
        tick();
        TXLOAD = 1'b0;
        model_load(v);
        check("txrdy_after_load", TXRDY, 0);
        check("txund_after_load", TXUND, m_und);
    endtask

    task automatic select_dev();
        nCS = 1'b0;
        repeat (8) tick();
        model_slot(cur_tx);
        check("active_sel", ACTIVE, 1);
        check("oe_sel", MISO_OE, 1);
        check("txund_sel", TXUND, m_und);
        check("txrdy_sel", TXRDY, !m_full);
    endtask

    task automatic deselect_dev();
        nCS = 1'b1;
        repeat (8) tick();
        check("active_desel", ACTIVE, 0);
        check("miso_desel", MISO, 1);
    endtask

    task automatic clock_bits(input logic [7:0] mo, input int n, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < n; i++) begin
            MOSI = mo[7-i];
            repeat (6) tick();
            got[7-i] = MISO;
            SCLK = 1'b1;
            repeat (6) tick();
            SCLK = 1'b0;
        end
    endtask

    // Full byte; optionally strobe TXLOAD exactly on the boundary slot cycle.
    task automatic xfer_byte(input logic [7:0] mo, input bit coin, input logic [7:0] cv);
        logic [7:0] got;
        logic       und_set;
        int         v0;
        v0 = rxv_cnt;
        clock_bits(mo, 8, got);
        check("miso_byte", got, cur_tx);
        check("rxd_byte", RXD, mo);
        check("rxvalid_pulses", rxv_cnt - v0, 1);
        m_rxd = mo;
        if (coin) begin
            tick();
            tick();
            TXD    = cv;
            TXLOAD = 1'b1;
            tick();
            check("coin_txrdy", TXRDY, 0);
            TXLOAD  = 1'b0;
            und_set = !m_full;
            model_slot(cur_tx);
            model_load(cv);
            if (und_set) m_und = 1'b1;
            repeat (5) tick();
        end else begin
            repeat (8) tick();
            model_slot(cur_tx);
        end
        check("txund_bound", TXUND, m_und);
        check("txrdy_bound", TXRDY, !m_full);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"}, MISO, 1);
        check({tag, "_oe"}, MISO_OE, 0);
        check({tag, "_active"}, ACTIVE, 0);
        check({tag, "_txrdy"}, TXRDY, 1);
        check({tag, "_txund"}, TXUND, 0);
        check({tag, "_rxd"}, RXD, 0);
        check({tag, "_rxvalid"}, RXVALID, 0);
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] v;
        int         v0;
        int         nb;

        nRES = 1'b0; nCS = 1'b1; SCLK = 1'b0; MOSI = 1'b1;
        TXLOAD = 1'b0; TXD = 8'h00;
        model_reset();
        cur_tx = 8'hFF;
        repeat (3) tick();
        check_reset_outputs("rst");
        nRES = 1'b1;
        repeat (3) tick();

        // Loaded byte sent while a byte is received.
        host_load(8'hA5);
        select_dev();
        xfer_byte(8'h3C, 1'b0, 8'h00);
        deselect_dev();

        // No data loaded: all-ones and underrun, cleared by a load.
        select_dev();
        xfer_byte($urandom_range(0, 255), 1'b0, 8'h00);
        xfer_byte($urandom_range(0, 255), 1'b0, 8'h00);
        deselect_dev();
        host_load(8'h81);
        select_dev();
        host_load(8'h42);
        host_load(8'h99);
        xfer_byte($urandom_range(0, 255), 1'b0, 8'h00);
        xfer_byte($urandom_range(0, 255), 1'b0, 8'h00);
        deselect_dev();

        // Randomized selections with random loads between slots.
        for (int s = 0; s < 6; s++) begin
            if ($urandom_range(0, 1) == 1) host_load($urandom_range(0, 255));
            select_dev();
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 1) == 1) host_load($urandom_range(0, 255));
                if ($urandom_range(0, 3) == 0) host_load($urandom_range(0, 255));
                xfer_byte($urandom_range(0, 255), 1'b0, 8'h00);
            end
            deselect_dev();
        end

        // Deselect mid-byte: nothing received, next selection is clean.
        host_load($urandom_range(0, 255));
        select_dev();
        v0 = rxv_cnt;
        clock_bits($urandom_range(0, 255), 5, got);
        deselect_dev();
        check("abort_rxvalid", rxv_cnt - v0, 0);
        check("abort_rxd", RXD, m_rxd);
        select_dev();
        xfer_byte($urandom_range(0, 255), 1'b0, 8'h00);
        deselect_dev();

        // Reset mid-transfer; nCS still low so release starts a new selection.
        host_load($urandom_range(0, 255));
        select_dev();
        clock_bits($urandom_range(0, 255), 4, got);
        nRES = 1'b0;
        tick();
        tick();
        check_reset_outputs("midrst");
        model_reset();
        nRES = 1'b1;
        repeat (8) tick();
        model_slot(cur_tx);
        check("postrst_active", ACTIVE, 1);
        check("postrst_txund", TXUND, m_und);
        xfer_byte($urandom_range(0, 255), 1'b0, 8'h00);
        deselect_dev();

        // Load coinciding with the byte-boundary slot while the buffer is full.
        host_load($urandom_range(0, 255));
        select_dev();
        host_load($urandom_range(0, 255));
        v = $urandom_range(0, 255);
        xfer_byte($urandom_range(0, 255), 1'b1, v);
        xfer_byte($urandom_range(0, 255), 1'b0, 8'h00);
        check("coin_next_byte", cur_tx, v);
        xfer_byte($urandom_range(0, 255), 1'b0, 8'h00);
        deselect_dev();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
